// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
//
// Multi-cycle multiply/divide unit for the RV32IM execute stage. It executes
// the eight M-extension operations (aluop 4'b1000..4'b1111: mul, mulh, mulhsu,
// mulhu, div, divu, rem, remu) on XLEN-bit operands. Multiplies use radix-2
// shift-add and divides use restoring division. Both work on operand
// magnitudes and retire one bit per cycle. The sign is applied in the DONE
// cycle.
//
// Timing: a start accepted in cycle 0 gives CALC in cycles 1..XLEN and a done
// pulse in cycle XLEN+1. Divide-by-zero and signed overflow are resolved at
// accept time, so they go straight from IDLE to DONE and done rises in cycle 1.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   When it is defined, multiplies use a single-cycle (XLEN+1)x(XLEN+1) signed
//   '*'. CALC then lasts one cycle and done rises in cycle 2. Divide timing
//   does not change. When it is undefined, no '*' operator is inferred.
//
// Parameters:
//   XLEN    operand/result width (>= 4)
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst_n   in   1     synchronous active-low reset
//   start   in   1     request, sampled only in IDLE
//   aluop   in   4     operation code, only 4'b1xxx accepted
//   a       in   XLEN  rs1 (multiplicand / dividend)
//   b       in   XLEN  rs2 (multiplier / divisor)
//   flush   in   1     abort the in-flight operation
//   busy    out  1     high from the cycle after accept through the DONE cycle
//   done    out  1     one-cycle pulse, result valid in the same cycle
//   result  out  XLEN  result word, held until the next done
// -----------------------------------------------------------------------------
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      aluop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   counter_q, counter_d;
    logic [2:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            special_q, special_d;
    // opd holds the operand that stays fixed during the iterations: the
    // multiplicand magnitude, or the divisor magnitude.
    logic [XLEN-1:0] opd_q, opd_d;
    // hi:lo is the product while multiplying. While dividing, hi is the partial
    // remainder and lo is the dividend as it turns into the quotient.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            calc_last;
    logic            in_a_signed, in_b_signed;
    logic            in_neg_a, in_neg_b;
    logic            in_div_zero, in_overflow, in_special;
    logic [XLEN-1:0] in_mag_a, in_mag_b, in_special_val;

    logic [XLEN:0]     div_shift, div_trial;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;

    // Zero-extended magnitudes make the signed multiplier act as an unsigned
    // one. The sign fix-up is then shared with the iterative path.
    assign fast_prod = (2*XLEN)'($signed({1'b0, opd_q}) * $signed({1'b0, lo_q}));
`else
    logic [XLEN:0] mul_sum;
`endif

    // Request decode. Signedness depends on the op. Special cases are found
    // here so that their result is known before any iteration runs.
    always_comb begin
        accept      = (state_q == S_IDLE) && start && aluop[3] && !flush;
        in_a_signed = (aluop[2:0] == 3'b001) || (aluop[2:0] == 3'b010) ||
                      (aluop[2:0] == 3'b100) || (aluop[2:0] == 3'b110);
        in_b_signed = (aluop[2:0] == 3'b001) || (aluop[2:0] == 3'b100) ||
                      (aluop[2:0] == 3'b110);
        in_neg_a    = in_a_signed && a[XLEN-1];
        in_neg_b    = in_b_signed && b[XLEN-1];
        in_mag_a    = in_neg_a ? (~a + 1'b1) : a;
        in_mag_b    = in_neg_b ? (~b + 1'b1) : b;
        in_div_zero = aluop[2] && (b == '0);
        in_overflow = aluop[2] && !aluop[0] && (a == INT_MIN) && (b == '1);
        in_special  = in_div_zero || in_overflow;
        if (in_div_zero) begin
            in_special_val = aluop[1] ? a : '1;
        end else begin
            in_special_val = aluop[1] ? '0 : a;
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign calc_last = !op_q[2] || (counter_q == LAST);
`else
    assign calc_last = (counter_q == LAST);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush wins over completion in CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (calc_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. In the DONE cycle the fixed-up value goes straight out.
    // After that the registered copy holds it.
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = done ? final_val : result_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            opd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
        end else begin
            counter_q <= counter_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            special_q <= special_d;
            opd_q     <= opd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    // Operand latch on accept, then one multiply or divide step per CALC cycle
    always_comb begin
        counter_d = '0;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        special_d = special_q;
        opd_d     = opd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_shift = '0;
        div_trial = '0;
`ifndef MDU_FAST_MUL_EN
        mul_sum   = '0;
`endif
        if (accept) begin
            op_d      = aluop[2:0];
            neg_a_d   = in_neg_a;
            neg_b_d   = in_neg_b;
            special_d = in_special;
            hi_d      = '0;
            if (in_special) begin
                opd_d = '0;
                lo_d  = in_special_val;
            end else if (aluop[2]) begin
                opd_d = in_mag_b;
                lo_d  = in_mag_a;
            end else begin
                opd_d = in_mag_a;
                lo_d  = in_mag_b;
            end
        end else if (state_q == S_CALC) begin
            if (state_d == S_CALC) begin
                counter_d = counter_q + 1'b1;
            end
            if (op_q[2]) begin
                // Restoring step. The remainder stays below the divisor, so
                // XLEN+1 bits are enough to hold the shifted trial.
                div_shift = {hi_q, lo_q[XLEN-1]};
                div_trial = div_shift - {1'b0, opd_q};
                if (!div_trial[XLEN]) begin
                    hi_d = div_trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
`ifdef MDU_FAST_MUL_EN
                {hi_d, lo_d} = fast_prod;
`else
                // Shift-add step. The multiplier bits leave lo from the
                // bottom while product bits enter it from the top.
                mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
                hi_d    = mul_sum[XLEN:1];
                lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
`endif
            end
        end
    end

    // Sign fix-up and result selection. The quotient is negative when the
    // operand signs differ. The remainder takes the dividend's sign.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
        quot_fix = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_a_q ? (~hi_q + 1'b1) : hi_q;
        if (special_q) begin
            final_val = lo_q;
        end else begin
            case (op_q)
                3'b000:                 final_val = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         final_val = quot_fix;
                default:                final_val = rem_fix;
            endcase
        end
        result_d = (state_q == S_DONE) ? final_val : result_q;
    end

endmodule
